// File: rtl/sw_enable_debounce.sv
// Switch synchronizer and debouncer feeding the breathing-LED enable.
// Emits a clean level, one-cycle press/release strobes and a toggle or level enable.
module sw_enable_debounce #(
  parameter int unsigned DB_CYCLES   = 250000,
  parameter int unsigned CNT_W       = 18,
  parameter bit          TOGGLE_MODE = 1'b1,
  parameter bit          INIT_EN     = 1'b0
) (
  input  logic sysclk,
  input  logic reset,
  input  logic sw_raw,
  output logic sw_level,
  output logic press,
  output logic sw_release,
  output logic enable
);

  // state      | meaning
  // STABLE_LO  | accepted level 0, input agrees
  // PEND_HI    | accepted level 0, input high, counting toward commit
  // STABLE_HI  | accepted level 1, input agrees
  // PEND_LO    | accepted level 1, input low, counting toward commit
  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             sw_level_q, sw_level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             enable_q, enable_d;
  logic             commit_rise, commit_fall;

  always_comb begin
    s1_d = sw_raw;
    s2_d = s1_q;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    commit_rise = 1'b0;
    commit_fall = 1'b0;
    case (state_q)
      STABLE_LO: begin
        if (s2_q) begin
          state_d = PEND_HI;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      PEND_HI: begin
        if (!s2_q) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = STABLE_HI;
          cnt_d       = '0;
          commit_rise = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STABLE_HI: begin
        if (!s2_q) begin
          state_d = PEND_LO;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      PEND_LO: begin
        if (s2_q) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = STABLE_LO;
          cnt_d       = '0;
          commit_fall = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are derived from the next state so they land on the commit edge.
  always_comb begin
    sw_level_d = (state_d == STABLE_HI) || (state_d == PEND_LO);
    press_d    = commit_rise;
    release_d  = commit_fall;
    enable_d   = enable_q;
    if (TOGGLE_MODE) begin
      if (commit_rise) enable_d = ~enable_q;
    end else begin
      if (commit_rise || commit_fall) enable_d = sw_level_d;
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q    <= STABLE_LO;
      cnt_q      <= '0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      sw_level_q <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      enable_q   <= INIT_EN;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      sw_level_q <= sw_level_d;
      press_q    <= press_d;
      release_q  <= release_d;
      enable_q   <= enable_d;
    end
  end

  assign sw_level   = sw_level_q;
  assign press      = press_q;
  assign sw_release = release_q;
  assign enable     = enable_q;

endmodule

// File: tb/tb_sw_enable_debounce.sv
// Directed bench for sw_enable_debounce: toggle-mode and level-mode instances
// share clock, reset and switch stimulus.
module tb_sw_enable_debounce;

  logic sysclk = 1'b0;
  logic reset;
  logic sw_raw;

  logic t_level, t_press, t_rel, t_en;
  logic l_level, l_press, l_rel, l_en;

  int n_chk  = 0;
  int n_fail = 0;

  int press_cyc = 0;
  int rel_cyc   = 0;
  int rel_edges = 0;
  int coinc     = 0;
  logic rel_prev = 1'b0;

  int snap_press, snap_rel, snap_edges;

  always #5 sysclk = ~sysclk;

  sw_enable_debounce #(
    .DB_CYCLES(4), .CNT_W(3), .TOGGLE_MODE(1'b1), .INIT_EN(1'b0)
  ) u_tog (
    .sysclk(sysclk), .reset(reset), .sw_raw(sw_raw),
    .sw_level(t_level), .press(t_press), .sw_release(t_rel), .enable(t_en)
  );

  sw_enable_debounce #(
    .DB_CYCLES(4), .CNT_W(3), .TOGGLE_MODE(1'b0), .INIT_EN(1'b1)
  ) u_lvl (
    .sysclk(sysclk), .reset(reset), .sw_raw(sw_raw),
    .sw_level(l_level), .press(l_press), .sw_release(l_rel), .enable(l_en)
  );

  always @(negedge sysclk) begin
    if (t_press) press_cyc <= press_cyc + 1;
    if (t_rel) rel_cyc <= rel_cyc + 1;
    if (t_rel && !rel_prev) rel_edges <= rel_edges + 1;
    if (t_press && t_rel) coinc <= coinc + 1;
    rel_prev <= t_rel;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  // Drive sw_raw for n cycles while the accepted level must not move.
  task automatic hold_quiet(input logic v, input int n, input string tag);
    sw_raw = v;
    for (int i = 0; i < n; i++) begin
      @(negedge sysclk);
      check_eq({tag, "_level"}, 32'(t_level), 32'd0);
      check_eq({tag, "_press"}, 32'(t_press), 32'd0);
      check_eq({tag, "_en"},    32'(t_en),    32'd0);
      check_eq({tag, "_lvl_en"}, 32'(l_en),   32'd1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    sw_raw = 1'b0;
    cycles(3);
    check_eq("rst_level",   32'(t_level), 32'd0);
    check_eq("rst_press",   32'(t_press), 32'd0);
    check_eq("rst_release", 32'(t_rel),   32'd0);
    check_eq("rst_en",      32'(t_en),    32'd0);
    check_eq("rst_lvl_en",  32'(l_en),    32'd1);
    reset = 1'b0;
    cycles(2);
    check_eq("lvl_en_idle", 32'(l_en), 32'd1);

    // Bounce: 3 high, 1 low, 3 high, then low; nothing may commit.
    hold_quiet(1'b1, 3, "bnc_a");
    hold_quiet(1'b0, 1, "bnc_b");
    hold_quiet(1'b1, 3, "bnc_c");
    hold_quiet(1'b0, 10, "bnc_d");

    snap_press = press_cyc;
    snap_rel   = rel_cyc;
    snap_edges = rel_edges;

    // Clean press: commit visible after edge 5 counted from the sampling edge.
    sw_raw = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge sysclk);
      check_eq("p1_pre_level", 32'(t_level), 32'd0);
      check_eq("p1_pre_press", 32'(t_press), 32'd0);
    end
    @(negedge sysclk);
    check_eq("p1_level",     32'(t_level), 32'd1);
    check_eq("p1_press",     32'(t_press), 32'd1);
    check_eq("p1_en",        32'(t_en),    32'd1);
    check_eq("p1_lvl_level", 32'(l_level), 32'd1);
    check_eq("p1_lvl_press", 32'(l_press), 32'd1);
    check_eq("p1_lvl_en",    32'(l_en),    32'd1);
    @(negedge sysclk);
    check_eq("p1_press_drop", 32'(t_press), 32'd0);
    check_eq("p1_level_hold", 32'(t_level), 32'd1);
    cycles(8);

    // Release: toggle enable holds, level enable drops 5 edges after the sample.
    sw_raw = 1'b0;
    cycles(5);
    check_eq("r1_pre_level", 32'(t_level), 32'd1);
    check_eq("r1_pre_lvl_en", 32'(l_en),   32'd1);
    @(negedge sysclk);
    check_eq("r1_level",   32'(t_level), 32'd0);
    check_eq("r1_release", 32'(t_rel),   32'd1);
    check_eq("r1_en",      32'(t_en),    32'd1);
    check_eq("r1_lvl_en",  32'(l_en),    32'd0);
    check_eq("r1_lvl_rel", 32'(l_rel),   32'd1);
    @(negedge sysclk);
    check_eq("r1_release_drop", 32'(t_rel), 32'd0);
    cycles(10);

    // Second press/release: enable toggles back to 0.
    sw_raw = 1'b1;
    cycles(5);
    check_eq("p2_pre_en", 32'(t_en), 32'd1);
    @(negedge sysclk);
    check_eq("p2_press",  32'(t_press), 32'd1);
    check_eq("p2_en",     32'(t_en),    32'd0);
    check_eq("p2_lvl_en", 32'(l_en),    32'd1);
    cycles(10);
    sw_raw = 1'b0;
    cycles(6);
    check_eq("r2_release", 32'(t_rel), 32'd1);
    check_eq("r2_en",      32'(t_en),  32'd0);
    check_eq("r2_lvl_en",  32'(l_en),  32'd0);
    cycles(10);
    check_eq("seq_press_cycles",   32'(press_cyc - snap_press), 32'd2);
    check_eq("seq_release_cycles", 32'(rel_cyc - snap_rel),     32'd2);
    check_eq("seq_release_pulses", 32'(rel_edges - snap_edges), 32'd2);

    // Reset mid-pending: reset sampled at edge 4 discards the count.
    sw_raw = 1'b1;
    cycles(4);
    reset = 1'b1;
    @(negedge sysclk);
    check_eq("mr_level",   32'(t_level), 32'd0);
    check_eq("mr_press",   32'(t_press), 32'd0);
    check_eq("mr_release", 32'(t_rel),   32'd0);
    check_eq("mr_en",      32'(t_en),    32'd0);
    check_eq("mr_lvl_en",  32'(l_en),    32'd1);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge sysclk);
      check_eq("mr_pre_level", 32'(t_level), 32'd0);
      check_eq("mr_pre_press", 32'(t_press), 32'd0);
    end
    @(negedge sysclk);
    check_eq("mr_post_press",     32'(t_press), 32'd1);
    check_eq("mr_post_level",     32'(t_level), 32'd1);
    check_eq("mr_post_en",        32'(t_en),    32'd1);
    check_eq("mr_post_lvl_level", 32'(l_level), 32'd1);
    check_eq("mr_post_lvl_en",    32'(l_en),    32'd1);
    cycles(2);

    check_eq("never_coincident", 32'(coinc), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
